count_ctrl: RTL and testbench

//  Control stage that sits directly upstream of the 2-bit-lab counter stage.
//  It generates the counter's clkEN tick and drives cnt2 for one counting run.
//  It sends the counter a clear pulse (cnt_rst) and consumes the counter's co2 terminal flag.

---
 rtl/count_ctrl.sv | 134 +++++++++++++
 tb/tb_count_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl.sv
// Control stage for the 2-bit-lab counter: clkEN prescaler, clear/run/done sequencing and a run watchdog.
// Optional build macro START_SYNC_EN: synchronise start and trigger runs on its rising edge only.
module count_ctrl #(
    parameter int unsigned DIV     = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       co2,
    output logic       clkEN,
    output logic       cnt2,
    output logic       cnt_rst,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [7:0]  WD_MAX   = 8'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    logic [15:0] presc;
    logic [7:0]  wdog;
    logic        start_req;

    // Host handshake: start is accepted in IDLE (ready=1) and in ERR; it is ignored in
    // CLR/RUN/DONE. done is a single-cycle completion pulse; err holds until the next start.

`ifdef START_SYNC_EN
    logic sync1, sync2, sync3, req_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            req_r <= 1'b0;
        end else begin
            sync1 <= start;
            sync2 <= sync1;
            sync3 <= sync2;
            req_r <= sync2 & ~sync3;
        end
    end

    assign start_req = req_r;
`else
    assign start_req = start;
`endif

    // Free-running prescaler; clkEN is registered so it is clean at the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= 16'd0;
            clkEN <= 1'b0;
        end else if (presc == DIV_LAST) begin
            presc <= 16'd0;
            clkEN <= 1'b1;
        end else begin
            presc <= presc + 16'd1;
            clkEN <= 1'b0;
        end
    end

    // Watchdog saturates at TIMEOUT so a stuck run can never wrap back to a small count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog <= 8'd0;
        end else if (state == CLR) begin
            wdog <= 8'd0;
        end else if (state == RUN && clkEN && wdog != WD_MAX) begin
            wdog <= wdog + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt2       = 1'b0;
        cnt_rst    = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start_req) state_next = CLR;
            end
            CLR: begin
                cnt_rst    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                // Gate the count enable the moment co2 is seen so the counter stops on its terminal value.
                cnt2 = ~co2;
                if (co2) begin
                    state_next = DONE;
                end else if (clkEN && wdog == WD_MAX) begin
                    state_next = ERR;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                err = 1'b1;
                if (start_req) state_next = CLR;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: two instances (DIV=4 and DIV=1), each driving a 3-bit
// counter model that raises co2 at count 5.
module tb_count_ctrl;

`ifdef START_SYNC_EN
    localparam int START_LAT = 4;
`else
    localparam int START_LAT = 1;
`endif

    typedef struct {
        logic       kill;
        logic [8:0] exp;   // {err, done, final count[2:0], clkEN ticks in RUN[3:0]}
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, kill_a = 1'b0;
    logic co2_a, clken_a, cnt2_a, cnt_rst_a, ready_a, done_a, err_a;
    logic co2_b, clken_b, cnt2_b, cnt_rst_b, ready_b, done_b, err_b;
    logic [2:0] dbg_a, dbg_b;
    logic [2:0] cnt_a, cnt_b;
    logic [8:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    count_ctrl #(.DIV(4), .TIMEOUT(8)) u_a (
        .clock(clock), .reset(reset), .start(start_a), .co2(co2_a), .clkEN(clken_a),
        .cnt2(cnt2_a), .cnt_rst(cnt_rst_a), .ready(ready_a), .done(done_a), .err(err_a),
        .dbg_state(dbg_a)
    );

    count_ctrl #(.DIV(1), .TIMEOUT(8)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .co2(co2_b), .clkEN(clken_b),
        .cnt2(cnt2_b), .cnt_rst(cnt_rst_b), .ready(ready_b), .done(done_b), .err(err_b),
        .dbg_state(dbg_b)
    );

    // Downstream counter models
    always @(posedge clock) begin
        if (reset || cnt_rst_a) cnt_a <= 3'd0;
        else if (clken_a && cnt2_a) cnt_a <= cnt_a + 3'd1;
        if (reset || cnt_rst_b) cnt_b <= 3'd0;
        else if (clken_b && cnt2_b) cnt_b <= cnt_b + 3'd1;
    end

    assign co2_a = (cnt_a == 3'd5) && !kill_a;
    assign co2_b = (cnt_b == 3'd5);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // The counter must never advance past its terminal value while co2 is live.
    always @(negedge clock) begin
        if (!reset && !kill_a) check("cnt_a_le_5", {31'd0, cnt_a <= 3'd5}, 1);
        if (!reset) check("cnt_b_le_5", {31'd0, cnt_b <= 3'd5}, 1);
    end

    task automatic run_vec(input vec_t v);
        int lat, ticks, held;
        logic seen_rst, fin;
        logic [8:0] act, exp;
        kill_a = v.kill;
        exp_q.push_back(v.exp);
        start_a = 1'b1;
        lat = 0;
        seen_rst = 1'b0;
        for (int c = 1; c <= 20 && !seen_rst; c++) begin
            @(negedge clock);
            if (c == 1) start_a = 1'b0;
            if (cnt_rst_a) begin
                seen_rst = 1'b1;
                lat = c;
            end
        end
        check("start_to_cnt_rst", lat, START_LAT);
        check("err_low_in_clr", {31'd0, err_a}, 0);
        check("ready_low_in_clr", {31'd0, ready_a}, 0);
        ticks = 0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clock);
            if (done_a || err_a) fin = 1'b1;
            else if (clken_a) ticks++;
        end
        check("run_finished", {31'd0, fin}, 1);
        act = {err_a, done_a, cnt_a, 4'(ticks)};
        exp = exp_q.pop_front();
        check("run_outcome", {23'd0, act}, {23'd0, exp});
        if (exp[8]) begin
            held = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                if (err_a) held++;
            end
            check("err_held", held, 5);
        end else begin
            @(negedge clock);
            check("done_one_cycle", {31'd0, done_a}, 0);
            check("ready_after_done", {31'd0, ready_a}, 1);
        end
        kill_a = 1'b0;
    endtask

    task automatic run_b();
        logic seen_rst, seen_co2;
        int off;
        start_b = 1'b1;
        seen_rst = 1'b0;
        for (int c = 1; c <= 20 && !seen_rst; c++) begin
            @(negedge clock);
            if (c == 1) start_b = 1'b0;
            if (cnt_rst_b) seen_rst = 1'b1;
        end
        check("b_cnt_rst_seen", {31'd0, seen_rst}, 1);
        seen_co2 = 1'b0;
        off = 0;
        for (int c = 1; c <= 30 && !seen_co2; c++) begin
            @(negedge clock);
            if (co2_b) begin
                seen_co2 = 1'b1;
                off = c;
                check("b_cnt2_gated_on_co2", {31'd0, cnt2_b}, 0);
                check("b_clken_with_co2", {31'd0, clken_b}, 1);
            end
        end
        check("b_co2_offset", off, 6);
        @(negedge clock);
        check("b_done", {31'd0, done_b}, 1);
        check("b_cnt_final", {29'd0, cnt_b}, 5);
        @(negedge clock);
    endtask

    vec_t vecs[4];
    int first_a, first_b, n_done, n_rst, d_cyc, r_cyc, ev;
    logic idle_again;

    initial begin
        vecs[0] = '{1'b0, {1'b0, 1'b1, 3'd5, 4'd5}};
        vecs[1] = '{1'b1, {1'b1, 1'b0, 3'd1, 4'd9}};
        vecs[2] = '{1'b0, {1'b0, 1'b1, 3'd5, 4'd5}};
        vecs[3] = '{1'b0, {1'b0, 1'b1, 3'd5, 4'd5}};

        // Reset held for three edges
        repeat (3) @(negedge clock);
        check("rst_state", {29'd0, dbg_a}, 0);
        check("rst_outs_a", {26'd0, clken_a, cnt2_a, cnt_rst_a, ready_a, done_a, err_a}, 6'b000100);
        check("rst_outs_b", {26'd0, clken_b, cnt2_b, cnt_rst_b, ready_b, done_b, err_b}, 6'b000100);
        reset = 1'b0;
        first_a = 0;
        first_b = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (i == 1) check("first_cycle_a", {27'd0, cnt2_a, cnt_rst_a, ready_a, done_a, err_a}, 5'b00100);
            if (clken_a && first_a == 0) first_a = i;
            if (clken_b && first_b == 0) first_b = i;
        end
        check("first_clken_div4", first_a, 4);
        check("first_clken_div1", first_b, 1);

        // Scoreboarded runs: normal, watchdog expiry, restart from ERR, normal
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // DIV=1: co2 and clkEN coincide; second run starts with a stale co2
        run_b();
        run_b();

        // start held high
        start_a = 1'b1;
        n_done = 0;
        n_rst = 0;
        d_cyc = -1;
        r_cyc = -1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clock);
            if (done_a) begin
                n_done++;
                if (d_cyc < 0) d_cyc = c;
            end
            if (cnt_rst_a) begin
                n_rst++;
                if (d_cyc >= 0 && r_cyc < 0) r_cyc = c;
            end
        end
        start_a = 1'b0;
`ifdef START_SYNC_EN
        check("held_start_one_run", n_rst, 1);
        check("held_start_one_done", n_done, 1);
`else
        check("held_start_rerun", {31'd0, n_done >= 2}, 1);
        check("done_to_cnt_rst_gap", r_cyc - d_cyc, 2);
`endif
        idle_again = 1'b0;
        for (int c = 0; c < 100 && !idle_again; c++) begin
            @(negedge clock);
            if (ready_a) idle_again = 1'b1;
        end
        check("idle_after_held", {31'd0, idle_again}, 1);
        repeat (2) @(negedge clock);

        // Reset mid-RUN
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        repeat (START_LAT + 8) @(negedge clock);
        check("midrun_cnt2_active", {31'd0, cnt2_a}, 1);
        reset = 1'b1;
        @(negedge clock);
        check("midrun_rst_state", {29'd0, dbg_a}, 0);
        check("midrun_rst_outs", {27'd0, cnt2_a, cnt_rst_a, ready_a, done_a, err_a}, 5'b00100);
        reset = 1'b0;
        ev = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done_a || err_a || cnt_rst_a) ev++;
        end
        check("midrun_no_done_err", ev, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
